// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// instruction_fetch_unit : PC, req/ack instruction fetch and instruction reg
// Revision: 1.0
// ============================================================================
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    PC_STEP     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pc_write,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   jump,
  input  logic [ADDR_WIDTH-1:0]  jump_target,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [5:0]             opcode_out,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic [ADDR_WIDTH-1:0]  pc_plus_out,
  output logic                   instr_valid,
  output logic                   misalign,
  output logic                   overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(PC_STEP - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  target_misaligned;

  // Request is decoded from state so an async reset withdraws it immediately.
  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign opcode_out  = instr_out[INSTR_WIDTH-1 -: 6];
  assign pc_plus_out = pc_out + STEP;

  always_comb begin
    redirect          = jump | branch_taken;
    redirect_target   = jump ? jump_target : branch_target;
    target_misaligned = 1'b0;
    next_pc           = pc + STEP;
    if (redirect) begin
      next_pc           = redirect_target & ~ALIGN_MASK;
      target_misaligned = |(redirect_target & ALIGN_MASK);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      pc_out      <= RESET_PC;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            instr_out   <= imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (pc_write) begin
            pc          <= next_pc;
            misalign    <= target_misaligned;
            instr_valid <= 1'b0;
            state       <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
      // A commit with nothing held is dropped but remembered until reset.
      if (pc_write && (state != S_HOLD)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_instruction_fetch_unit : directed table, hand sequences, random vs model
// Revision: 1.0
// ============================================================================
module tb_instruction_fetch_unit;

  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pc_write = 1'b0, branch_taken = 1'b0, jump = 1'b0, imem_ack = 1'b0;
  logic [AW-1:0] branch_target = '0, jump_target = '0;
  logic [IW-1:0] imem_rdata = '0;

  logic          imem_req, instr_valid, misalign, overrun;
  logic [AW-1:0] imem_addr, pc_out, pc_plus_out;
  logic [IW-1:0] instr_out;
  logic [5:0]    opcode_out;

  logic          b_imem_req, b_instr_valid, b_misalign, b_overrun;
  logic [AW-1:0] b_imem_addr, b_pc_out, b_pc_plus_out;
  logic [IW-1:0] b_instr_out;
  logic [5:0]    b_opcode_out;

  instruction_fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .opcode_out(opcode_out), .pc_out(pc_out), .pc_plus_out(pc_plus_out),
    .instr_valid(instr_valid), .misalign(misalign), .overrun(overrun)
  );

  instruction_fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
    .clk(clk), .reset(reset), .pc_write(pc_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_out(b_instr_out), .opcode_out(b_opcode_out), .pc_out(b_pc_out), .pc_plus_out(b_pc_plus_out),
    .instr_valid(b_instr_valid), .misalign(b_misalign), .overrun(b_overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: "have an instruction or not", plus the architectural PC.
  bit            m_started, m_have, m_over, m_mis;
  logic [AW-1:0] m_pc, m_ipc;
  logic [IW-1:0] m_instr;

  function automatic void model_reset();
    m_started = 0; m_have = 0; m_over = 0; m_mis = 0;
    m_pc = '0; m_ipc = '0; m_instr = '0;
  endfunction

  function automatic void model_step();
    logic [AW-1:0] t;
    m_mis = 0;
    if (!m_started) begin
      m_started = 1;
      if (pc_write) m_over = 1;
    end else if (!m_have) begin
      if (pc_write) m_over = 1;
      if (imem_ack) begin
        m_instr = imem_rdata; m_ipc = m_pc; m_have = 1;
      end
    end else if (pc_write) begin
      m_have = 0;
      if (jump || branch_taken) begin
        t     = jump ? jump_target : branch_target;
        m_mis = (t % 4) != 0;
        m_pc  = t - (t % 4);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".req"},    imem_req,    m_started && !m_have);
    chk({tag, ".addr"},   imem_addr,   m_pc);
    chk({tag, ".valid"},  instr_valid, m_have);
    chk({tag, ".instr"},  instr_out,   m_instr);
    chk({tag, ".opcode"}, opcode_out,  m_instr / 32'h0400_0000);
    chk({tag, ".mis"},    misalign,    m_mis);
    chk({tag, ".over"},   overrun,     m_over);
    if (m_have) begin
      chk({tag, ".pc_out"},  pc_out,      m_ipc);
      chk({tag, ".pc_plus"}, pc_plus_out, m_ipc + 32'd4);
    end
  endtask

  task automatic tick();
    if (reset) model_reset(); else model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic pw, jmp, br, ack;
    logic [31:0] jt, bt, rdata;
    logic req; logic [31:0] addr; logic valid; logic [5:0] op; logic [31:0] pcplus; logic mis, over;
  } vec_t;

  function automatic vec_t mk(input logic pw, jmp, br, ack, input logic [31:0] jt, bt, rdata,
                              input logic req, input logic [31:0] addr, input logic valid,
                              input logic [5:0] op, input logic [31:0] pcplus, input logic mis, over);
    vec_t v;
    v.pw = pw; v.jmp = jmp; v.br = br; v.ack = ack; v.jt = jt; v.bt = bt; v.rdata = rdata;
    v.req = req; v.addr = addr; v.valid = valid; v.op = op; v.pcplus = pcplus; v.mis = mis; v.over = over;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    tbl[0]  = mk(0,0,0,0, 0,0,0,              1, 32'h0,   0, 6'h00, 0,        0,0);
    tbl[1]  = mk(0,0,0,1, 0,0,32'h04221000,   0, 32'h0,   1, 6'h01, 32'h4,    0,0);
    tbl[2]  = mk(1,1,1,0, 32'h40,32'h80,0,    1, 32'h40,  0, 6'h01, 0,        0,0);
    tbl[3]  = mk(0,0,0,1, 0,0,32'h08000000,   0, 32'h40,  1, 6'h02, 32'h44,   0,0);
    tbl[4]  = mk(1,0,1,0, 0,32'h80,0,         1, 32'h80,  0, 6'h02, 0,        0,0);
    tbl[5]  = mk(0,0,0,0, 0,0,0,              1, 32'h80,  0, 6'h02, 0,        0,0);
    tbl[6]  = mk(0,1,1,0, 32'h999,32'h777,0,  1, 32'h80,  0, 6'h02, 0,        0,0);
    tbl[7]  = mk(0,0,0,1, 0,0,32'hFC000000,   0, 32'h80,  1, 6'h3F, 32'h84,   0,0);
    tbl[8]  = mk(1,0,1,0, 0,32'h103,0,        1, 32'h100, 0, 6'h3F, 0,        1,0);
    tbl[9]  = mk(0,0,0,0, 0,0,0,              1, 32'h100, 0, 6'h3F, 0,        0,0);
    tbl[10] = mk(0,0,0,1, 0,0,32'h0C000000,   0, 32'h100, 1, 6'h03, 32'h104,  0,0);
    tbl[11] = mk(1,0,0,0, 0,0,0,              1, 32'h104, 0, 6'h03, 0,        0,0);
    tbl[12] = mk(1,0,0,0, 0,0,0,              1, 32'h104, 0, 6'h03, 0,        0,1);
    tbl[13] = mk(0,0,0,1, 0,0,32'h10000000,   0, 32'h104, 1, 6'h04, 32'h108,  0,1);
    tbl[14] = mk(0,0,0,1, 0,0,32'hFFFFFFFF,   0, 32'h104, 1, 6'h04, 32'h108,  0,1);

    // Reset state
    model_reset();
    tick(); tick();
    chk("rst.req",   imem_req, 0);
    chk("rst.addr",  imem_addr, 32'h0);
    chk("rst.valid", instr_valid, 0);
    chk("rst.instr", instr_out, 32'h0);
    chk("rst.mis",   misalign, 0);
    chk("rst.over",  overrun, 0);
    chk("rst.wrap_addr", b_imem_addr, 32'hFFFF_FFFC);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      pc_write = tbl[i].pw; jump = tbl[i].jmp; branch_taken = tbl[i].br; imem_ack = tbl[i].ack;
      jump_target = tbl[i].jt; branch_target = tbl[i].bt; imem_rdata = tbl[i].rdata;
      tick();
      chk($sformatf("tbl%0d.req", i),   imem_req,    tbl[i].req);
      chk($sformatf("tbl%0d.addr", i),  imem_addr,   tbl[i].addr);
      chk($sformatf("tbl%0d.valid", i), instr_valid, tbl[i].valid);
      chk($sformatf("tbl%0d.op", i),    opcode_out,  tbl[i].op);
      chk($sformatf("tbl%0d.mis", i),   misalign,    tbl[i].mis);
      chk($sformatf("tbl%0d.over", i),  overrun,     tbl[i].over);
      if (tbl[i].valid) chk($sformatf("tbl%0d.pcplus", i), pc_plus_out, tbl[i].pcplus);
    end
    pc_write = 0; jump = 0; branch_taken = 0; imem_ack = 0;

    // Reset asserted mid-cycle while a request is outstanding
    pc_write = 1; tick(); pc_write = 0;
    model_check("pre_rst");
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("async.req",   imem_req, 0);
    chk("async.valid", instr_valid, 0);
    chk("async.over",  overrun, 0);
    chk("async.addr",  imem_addr, 32'h0);
    imem_ack = 1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("rstack.valid", instr_valid, 0);
    chk("rstack.instr", instr_out, 32'h0);
    imem_ack = 0; reset = 1'b0;
    tick();
    model_check("refetch");

    // Sequential commits: 0, 4, 8 here and wrap from 0xFFFFFFFC on the second instance
    for (int k = 0; k < 2; k++) begin
      imem_ack = 1; imem_rdata = $urandom; tick(); imem_ack = 0;
      model_check($sformatf("seq%0d.hold", k));
      pc_write = 1; tick(); pc_write = 0;
      model_check($sformatf("seq%0d.fetch", k));
      if (k == 0) chk("wrap.addr", b_imem_addr, 32'h0);
    end
    chk("seq.addr8", imem_addr, 32'h8);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 299) == 0);
      pc_write     = ($urandom_range(0, 3) == 0);
      jump         = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 2) == 0);
      jump_target  = $urandom;
      branch_target = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      imem_ack     = ($urandom_range(0, 1) == 0);
      imem_rdata   = $urandom;
      tick();
      model_check($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the decode/control unit. Holds the program counter and runs a request/acknowledge read to instruction memory. It latches the returned word into the instruction register and presents the 6-bit opcode plus PC values to decode. The PC advances only when decode pulses pc_write; the next PC is selected from sequential, branch or jump target.

Parameters:
ADDR_WIDTH, 32, width of PC and instruction-memory address
INSTR_WIDTH, 32, instruction word width; opcode is bits [INSTR_WIDTH-1 -: 6]
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, sequential PC increment (byte addressing)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pc_write  input  1  one-cycle pulse from control: commit current instruction, advance PC
branch_taken  input  1  select branch_target on pc_write
branch_target  input  ADDR_WIDTH  branch destination
jump  input  1  select jump_target on pc_write (priority over branch)
jump_target  input  ADDR_WIDTH  jump destination
imem_req  output  1  instruction-memory read request
imem_addr  output  ADDR_WIDTH  read address (= pc)
imem_ack  input  1  memory ack; imem_rdata valid in the same cycle
imem_rdata  input  INSTR_WIDTH  instruction word from memory
instr_out  output  INSTR_WIDTH  instruction register
opcode_out  output  6  instr_out[INSTR_WIDTH-1 -: 6], feeds control opcode
pc_out  output  ADDR_WIDTH  address of the instruction in instr_out
pc_plus_out  output  ADDR_WIDTH  pc_out + PC_STEP
instr_valid  output  1  instr_out holds a fetched, uncommitted instruction
misalign  output  1  one-cycle pulse: selected target had nonzero low bits
overrun  output  1  sticky: pc_write arrived while no instruction was held

Behaviour:
- States: IDLE, FETCH, HOLD. On reset (async, immediate): state=IDLE, pc=RESET_PC, instr_out=0 (opcode 0x00 = NOP to control), imem_req=0, instr_valid=0, misalign=0, overrun=0.
- IDLE: unconditionally moves to FETCH on the next clk edge. IDLE is entered only after reset.
- FETCH: imem_req=1 and imem_addr=pc, held stable until ack; the request is never withdrawn. On the imem_ack edge: instr_out<=imem_rdata, instr_valid<=1, go to HOLD, and imem_req drops in the following cycle. Minimum latency from request to instr_valid is 1 cycle (ack in the first request cycle).
- HOLD: instr_out, pc_out and instr_valid stay stable; imem_req=0. On a pc_write edge, the next pc is:
  - jump_target if jump=1;
  - otherwise branch_target if branch_taken=1;
  - otherwise pc+PC_STEP.
  On the same edge: instr_valid<=0 and the state goes to FETCH.
- Target alignment: the low log2(PC_STEP) bits of the selected target are forced to 0; if any were set, misalign pulses for exactly one cycle.
- Arithmetic: pc+PC_STEP wraps modulo 2^ADDR_WIDTH with no flag. pc_plus_out uses the same wrap.
- pc_write in IDLE or FETCH: ignored (pc unchanged, request not restarted) and overrun<=1. overrun clears only on reset.
- jump, branch_taken and the targets are sampled only on a pc_write edge in HOLD; at all other times they are don't-care.
- imem_ack outside FETCH is ignored.
- Reset mid-FETCH: imem_req drops asynchronously and the pending ack is discarded. The fetch restarts from RESET_PC via IDLE.
- Back-to-back: pc_write in HOLD leads to FETCH in the next cycle, so a new request is issued 1 cycle after commit.

Test Plan:
- Reset release, memory acks in the first request cycle with 0x04221000 -> imem_req high at edge 1, addr 0x0; instr_valid high from edge 2; opcode_out=0x01; pc_plus_out=0x4.
- Ack delayed 3 cycles -> imem_addr and imem_req held stable for all 3 wait cycles; instr_out changes only on the ack edge.
- Three pc_write pulses with no redirect -> fetch addresses 0x0, 0x4, 0x8. With RESET_PC=0xFFFFFFFC, the next address wraps to 0x0.
- pc_write with jump=1 (target 0x40) and branch_taken=1 (target 0x80) together -> next imem_addr=0x40. With branch only -> 0x80.
- Branch target 0x103 -> imem_addr=0x100 and misalign high for exactly 1 cycle.
- pc_write during FETCH -> pc unchanged and overrun=1 persisting. Assert reset while imem_req is high, then ack -> ack ignored, outputs return to reset values, refetch from RESET_PC.
